mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive cycles one requester holds the mux while others wait (legal range 1..15).
REQ-002 Port: CLK  input  1  sole clock, rising-edge active.
REQ-003 Port: RST_N  input  1  asynchronous, active-low reset.
REQ-004 Port: REQ  input  4  request lines; REQ[0]..REQ[3] own mux inputs A..D.
REQ-005 Port: GNT  output  4  one-hot grant; all zero when idle.
REQ-006 Port: S0  output  1  mux select LSB, drives MUX S0.
REQ-007 Port: S1  output  1  mux select MSB, drives MUX S1.
REQ-008 Port: VALID  output  1  high while a grant is active, meaning mux output O is owned.
REQ-009 Port: OWNER  output  2  binary index of the current or last owner, equal to {S1,S0}.

Function
REQ-010 All outputs SHALL be registered; no combinational path from REQ to any output.
REQ-011 The state machine SHALL have two states: IDLE and GRANT.
REQ-012 IDLE -> GRANT on any clock edge with REQ != 0; winner chosen round-robin, searching upward (mod 4) from last owner + 1.
REQ-013 Grant latency SHALL be exactly 1 cycle: REQ sampled at edge N -> GNT/VALID/select valid after edge N.
REQ-014 In GRANT, while REQ[owner]=1 and hold count < MAX_HOLD, the grant SHALL stay unchanged.
REQ-015 Hold counter: 4 bits, loaded to 1 on each new grant, incremented each cycle the grant is kept; saturation never reached (MAX_HOLD <= 15).
REQ-016 In GRANT, when REQ[owner]=0 at an edge: if another REQ is high, the grant SHALL pass at that edge to the round-robin winner (no idle bubble); otherwise go to IDLE.
REQ-017 When hold count = MAX_HOLD and REQ[owner]=1: if any other REQ is high, the grant SHALL rotate to the round-robin winner excluding the owner; otherwise the owner keeps the grant and the counter reloads to 1.
REQ-018 GNT SHALL always equal one-hot decode of OWNER when VALID=1, and 4'b0000 when VALID=0.
REQ-019 In IDLE, S1/S0/OWNER SHALL hold the last owner value (mux select stable, no glitching).
REQ-020 Simultaneous requests: exactly one grant; the round-robin pointer guarantees every continuously requesting line a grant within 3*MAX_HOLD+3 cycles.
REQ-021 A request line rising and falling in the same cycle between edges SHALL be ignored (sampling only at edges).

Reset
REQ-022 RST_N low SHALL immediately, without a clock, force: state IDLE, GNT=4'b0000, VALID=0, S1=0, S0=0, OWNER=2'd0, hold count 0, round-robin pointer "last owner"=3 so REQ[0] has highest priority first.
REQ-023 Reset asserted mid-grant SHALL drop the grant immediately; after release the first edge with REQ != 0 arbitrates as from power-up.
REQ-024 Release of RST_N SHALL take effect on the first rising CLK edge after deassertion; no grant is issued on the release edge unless REQ is sampled there.

Verification
REQ-025 Reset, then REQ=4'b1111 at one edge -> next cycle GNT=0001, {S1,S0}=00, VALID=1.
REQ-026 MAX_HOLD=8, REQ=4'b1111 held -> grants 0001,0010,0100,1000 each for exactly 8 cycles, then repeats from 0001.
REQ-027 Only REQ[2] held for 20 cycles -> GNT=0100 continuously, no VALID drop at the hold boundary; then REQ=0 -> VALID=0 next cycle, {S1,S0} stays 10.
REQ-028 Owner 1 holding, REQ[1] drops while REQ[3] high -> GNT goes 0010 -> 1000 in one edge, VALID never low.
REQ-029 Reset pulsed low mid-grant (owner 3) between clock edges -> GNT=0000, VALID=0, {S1,S0}=00 immediately; after release REQ=4'b1010 -> GNT=0010.
REQ-030 Integrated with the 4:1 MUX: A..D driven with distinct patterns, mux output O SHALL equal the data of the granted input every cycle VALID=1.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a 4:1 mux, with a per-owner hold limit.
// One-cycle grant latency, all outputs registered; requesters simply wait while REQ is held.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic       S0,
  output logic       S1,
  output logic       VALID,
  output logic [1:0] OWNER
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] others;
  logic [1:0] win_idle, win_any, win_oth;

  // First set bit of req searching upward (mod 4) from last+1.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign others   = REQ & ~(4'b0001 << owner_q);
  assign win_idle = rr_pick(REQ, ptr_q);
  assign win_any  = rr_pick(REQ, owner_q);
  assign win_oth  = rr_pick(others, owner_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    gnt_d   = 4'b0000;
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          state_d = GRANT;
          owner_d = win_idle;
          hold_d  = 4'd1;
        end
      end
      GRANT: begin
        if (REQ[owner_q]) begin
          if (hold_q < MaxHold) begin
            hold_d = hold_q + 4'd1;
          end else begin
            // Hold limit hit: rotate only if someone else is waiting.
            if (|others) owner_d = win_oth;
            hold_d = 4'd1;
          end
        end else if (|REQ) begin
          owner_d = win_any;
          hold_d  = 4'd1;
        end else begin
          state_d = IDLE;
          hold_d  = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == GRANT) begin
      ptr_d = owner_d;
      gnt_d = 4'b0001 << owner_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd3;
      hold_q  <= 4'd0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  assign GNT   = gnt_q;
  assign VALID = (state_q == GRANT);
  assign OWNER = owner_q;
  assign S0    = owner_q[0];
  assign S1    = owner_q[1];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed scenarios plus randomized requests against a reference model.
module tb_mux_rr_arbiter;

  localparam int MH = 8;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic [3:0] GNT;
  logic       S0, S1, VALID;
  logic [1:0] OWNER;

  logic [7:0] din [4];
  logic [7:0] mux_o;

  typedef struct {
    bit valid;
    int owner;
    int rr_ptr;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_active;
  int m_owner, m_ptr, m_hold;

  mux_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .GNT(GNT),
    .S0(S0), .S1(S1), .VALID(VALID), .OWNER(OWNER)
  );

  always #5 CLK = ~CLK;

  assign mux_o = din[{S1, S0}];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_from(input logic [3:0] r, input int after);
    for (int k = 1; k <= 4; k++)
      if (r[(after + k) % 4]) return (after + k) % 4;
    return -1;
  endfunction

  function automatic void model_reset();
    m_active = 0;
    m_owner  = 0;
    m_ptr    = 3;
    m_hold   = 0;
  endfunction

  function automatic void give(input int w);
    m_active = 1;
    m_owner  = w;
    m_ptr    = w;
    m_hold   = 1;
  endfunction

  function automatic void model_step(input logic [3:0] r);
    logic [3:0] oth;
    exp_t e;
    if (!m_active) begin
      if (r != 0) give(rr_from(r, m_ptr));
    end else if (r[m_owner]) begin
      if (m_hold < MH) m_hold++;
      else begin
        oth = r;
        oth[m_owner] = 1'b0;
        if (oth != 0) give(rr_from(oth, m_owner));
        else m_hold = 1;
      end
    end else if (r != 0) begin
      give(rr_from(r, m_owner));
    end else begin
      m_active = 0;
    end
    e.valid  = m_active;
    e.owner  = m_owner;
    e.rr_ptr = m_ptr;
    sb.push_back(e);
  endfunction

  // Drive one cycle's request; glitch bits toggle between edges and must be ignored.
  task automatic step(input logic [3:0] r, input logic [3:0] glitch = 4'b0000);
    REQ = r ^ glitch;
    #2;
    REQ = r;
    for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
    @(posedge CLK);
    model_step(r);
    #1;
  endtask

  task automatic reset_pulse();
    RST_N = 1'b0;
    #1;
    check("rst_gnt", int'(GNT), 0);
    check("rst_valid", int'(VALID), 0);
    check("rst_sel", int'({S1, S0}), 0);
    check("rst_owner", int'(OWNER), 0);
    sb.delete();
    model_reset();
    #1;
    RST_N = 1'b1;
  endtask

  // Monitor: compare registered outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_N && sb.size() > 0) begin
        e = sb.pop_front();
        check("valid", int'(VALID), int'(e.valid));
        check("gnt", int'(GNT), e.valid ? (1 << e.owner) : 0);
        check("owner", int'(OWNER), e.owner);
        check("sel", int'({S1, S0}), e.owner);
        if (e.valid) check("mux_o", int'(mux_o), int'(din[e.owner]));
      end
    end
  end

  initial begin
    logic [3:0] r;
    model_reset();
    for (int i = 0; i < 4; i++) din[i] = 8'(i);
    #12;
    check("por_gnt", int'(GNT), 0);
    check("por_valid", int'(VALID), 0);
    check("por_sel", int'({S1, S0}), 0);
    check("por_owner", int'(OWNER), 0);
    #10;
    RST_N = 1'b1;

    // No request on release edge: no grant; then all request, each holds exactly MH cycles.
    step(4'b0000);
    step(4'b1111);
    for (int i = 0; i < 5 * MH; i++) step(4'b1111);

    // Sole requester keeps grant across hold boundary, then releases.
    for (int i = 0; i < 20; i++) step(4'b0100);
    step(4'b0000);
    step(4'b0000);

    // Owner 1 drops while 3 waits: handover in one edge.
    step(4'b0010);
    step(4'b1010);
    step(4'b1010);
    step(4'b1000);
    step(4'b1000);

    // Reset between edges while owner 3 holds, then 1010 arbitrates from power-up.
    reset_pulse();
    step(4'b1010);
    step(4'b1010);

    // Glitches between edges are invisible.
    step(4'b0000, 4'b1111);
    step(4'b0000, 4'b0101);

    // Randomized traffic with sticky requests and occasional resets.
    r = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      if ($urandom_range(0, 199) == 0) reset_pulse();
      step(r, ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000);
    end
    step(4'b0000);
    @(negedge CLK);
    #1;
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
